// File: rtl/bridge_txn_tracker.sv
// Transaction tracker for the AXI2APB bridge: circular pool of burst entries,
// split into serial APB beats, worst-response accumulation, in-order retirement.
module bridge_txn_tracker #(
    parameter  int ID_WIDTH     = 1,
    parameter  int ADDR_WIDTH   = 32,
    parameter  int LG2_NUM_BUFS = 2,
    localparam int INFO_W       = ID_WIDTH + ADDR_WIDTH + 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic                    alloc_type,
    input  logic [INFO_W-1:0]       alloc_info,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic                    issue_type,
    output logic [ADDR_WIDTH-1:0]   issue_addr,
    output logic [ID_WIDTH-1:0]     issue_id,
    output logic                    issue_last,
    input  logic                    cmpl_valid,
    input  logic [1:0]              cmpl_resp,
    output logic                    ret_valid,
    input  logic                    ret_ready,
    output logic                    ret_type,
    output logic [ID_WIDTH-1:0]     ret_id,
    output logic [1:0]              ret_resp,
    output logic [LG2_NUM_BUFS:0]   occupancy
);

    localparam int NUM_BUFS = 1 << LG2_NUM_BUFS;
    localparam int PTR_W    = (LG2_NUM_BUFS > 0) ? LG2_NUM_BUFS : 1;
    localparam logic [LG2_NUM_BUFS:0] NUM_BUFS_C = (LG2_NUM_BUFS + 1)'(NUM_BUFS);

    typedef enum logic {BB_READ = 1'b0, BB_WRITE = 1'b1} bb_type_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [1:0]            burst;
        logic [2:0]            size;
    } addr_info_t;

    typedef enum logic [1:0] {FREE, PENDING, ACTIVE, DONE} ent_state_t;

    ent_state_t       state [NUM_BUFS];
    bb_type_t         etype [NUM_BUFS];
    addr_info_t       info  [NUM_BUFS];
    logic [1:0]       eresp [NUM_BUFS];

    logic [PTR_W-1:0]        alloc_ptr, issue_ptr, retire_ptr;
    logic [7:0]              beat_cnt;
    logic [ADDR_WIDTH-1:0]   addr_off;
    logic [1:0]              resp_acc;
    logic                    in_flight;
    logic [LG2_NUM_BUFS:0]   occ;

    addr_info_t              cur;
    ent_state_t              cur_st;
    logic                    last_beat;
    logic [1:0]              resp_new;
    logic [ADDR_WIDTH-1:0]   beat_bytes;
    logic                    alloc_fire, issue_fire, cmpl_fire, ret_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (NUM_BUFS == 1) return '0;
        return p + 1'b1;
    endfunction

    assign cur        = info[issue_ptr];
    assign cur_st     = state[issue_ptr];
    assign last_beat  = (beat_cnt == cur.len);
    assign resp_new   = (cmpl_resp > resp_acc) ? cmpl_resp : resp_acc;
    assign beat_bytes = ADDR_WIDTH'(1) << cur.size;

    // Full pool blocks allocation even if an entry retires this cycle.
    assign alloc_ready = (occ < NUM_BUFS_C);
    assign issue_valid = ((cur_st == PENDING) || (cur_st == ACTIVE)) && !in_flight;
    assign issue_type  = etype[issue_ptr];
    assign issue_addr  = cur.addr + addr_off;
    assign issue_id    = cur.id;
    assign issue_last  = issue_valid & last_beat;
    assign ret_valid   = (state[retire_ptr] == DONE);
    assign ret_type    = etype[retire_ptr];
    assign ret_id      = info[retire_ptr].id;
    assign ret_resp    = eresp[retire_ptr];
    assign occupancy   = occ;

    assign alloc_fire = alloc_valid & alloc_ready;
    assign issue_fire = issue_valid & issue_ready;
    assign cmpl_fire  = cmpl_valid & in_flight;
    assign ret_fire   = ret_valid & ret_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                state[i] <= FREE;
                etype[i] <= BB_READ;
                info[i]  <= '0;
                eresp[i] <= '0;
            end
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            beat_cnt   <= '0;
            addr_off   <= '0;
            resp_acc   <= '0;
            in_flight  <= 1'b0;
            occ        <= '0;
        end else begin
            // Alloc, issue/complete and retire always hit distinct entries.
            if (alloc_fire) begin
                state[alloc_ptr] <= PENDING;
                etype[alloc_ptr] <= bb_type_t'(alloc_type);
                info[alloc_ptr]  <= alloc_info;
                alloc_ptr        <= ptr_inc(alloc_ptr);
            end
            if (issue_fire) begin
                in_flight <= 1'b1;
                if (cur_st == PENDING) state[issue_ptr] <= ACTIVE;
            end
            if (cmpl_fire) begin
                in_flight <= 1'b0;
                if (last_beat) begin
                    state[issue_ptr] <= DONE;
                    eresp[issue_ptr] <= resp_new;
                    resp_acc         <= '0;
                    beat_cnt         <= '0;
                    addr_off         <= '0;
                    issue_ptr        <= ptr_inc(issue_ptr);
                end else begin
                    resp_acc <= resp_new;
                    beat_cnt <= beat_cnt + 1'b1;
                    // FIXED repeats the base address; WRAP and reserved step like INCR.
                    if (cur.burst != 2'b00) addr_off <= addr_off + beat_bytes;
                end
            end
            if (ret_fire) begin
                state[retire_ptr] <= FREE;
                retire_ptr        <= ptr_inc(retire_ptr);
            end
            case ({alloc_fire, ret_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
